// File: rtl/bpf_pkt_pkg.sv
// Shared definitions for the BPF packet read port: transfer-size codes, FSM states and helpers.
package bpf_pkt_pkg;

    localparam logic [1:0] SZ_W   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_B   = 2'b10;
    localparam logic [1:0] SZ_ILL = 2'b11;

    // Word 0 is read in the accept cycle itself, so the first busy state is either
    // RD1 (issue word 1 of a span) or WAIT.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD1  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } pkt_rd_state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_W:    n = 3'd4;
            SZ_H:    n = 3'd2;
            SZ_B:    n = 3'd1;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bpf_byte_extract.sv
// Picks n bytes starting at a byte offset out of a two-word big-endian window, zero-extended.
module bpf_byte_extract
    import bpf_pkt_pkg::*;
(
    input  logic [63:0] i_window,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_sz,
    output logic [31:0] o_value
);

    logic [63:0] w_shifted;

    always_comb begin
        // Left-align the first requested byte at bit 63
        w_shifted = i_window << {i_offset, 3'b000};
        case (i_sz)
            SZ_W:    o_value = w_shifted[63:32];
            SZ_H:    o_value = {16'h0000, w_shifted[63:48]};
            SZ_B:    o_value = {24'h000000, w_shifted[63:56]};
            default: o_value = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/bpf_pkt_rd_port.sv
// Packet-memory read responder for the BPF core: bounds check, 1 or 2 BRAM word reads,
// big-endian assembly and a one-cycle mem_ready strobe.
module bpf_pkt_rd_port
    import bpf_pkt_pkg::*;
#(
    parameter int unsigned PACKET_BYTE_ADDR_WIDTH = 12,
    parameter int unsigned PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2,
    parameter int unsigned BRAM_LATENCY           = 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_rd_en,
    input  logic [PACKET_BYTE_ADDR_WIDTH-1:0] i_byte_addr,
    input  logic [1:0]                        i_transfer_sz,
    input  logic [31:0]                       i_packet_len,
    output logic [31:0]                       o_rd_data,
    output logic                              o_mem_ready,
    output logic                              o_oob,
    output logic                              o_bram_rd_en,
    output logic [PACKET_ADDR_WIDTH-1:0]      o_bram_addr,
    input  logic [31:0]                       i_bram_rdata
);

    localparam logic [32:0] MEM_BYTES = 33'd1 << PACKET_BYTE_ADDR_WIDTH;
    localparam logic [1:0]  LAT_M1    = 2'(BRAM_LATENCY - 1);
    localparam logic [PACKET_ADDR_WIDTH-1:0] ONE_WORD = {{(PACKET_ADDR_WIDTH-1){1'b0}}, 1'b1};

    pkt_rd_state_e                  r_state;
    logic [1:0]                     r_cnt;
    logic [PACKET_ADDR_WIDTH-1:0]   r_word;
    logic [1:0]                     r_off;
    logic [1:0]                     r_sz;
    logic                           r_span;
    logic [31:0]                    r_w0;
    logic [BRAM_LATENCY-1:0]        r_w0_pipe;
    logic [31:0]                    r_rd_data;
    logic                           r_mem_ready;
    logic                           r_oob;

    logic [2:0]                     w_n;
    logic [32:0]                    w_end;
    logic                           w_accept;
    logic                           w_oob;
    logic                           w_span;
    logic                           w_rd_ok;
    logic [63:0]                    w_window;
    logic [31:0]                    w_value;

    always_comb begin
        w_n      = size_bytes(i_transfer_sz);
        w_end    = 33'(i_byte_addr) + 33'(w_n);
        // Reset also masks the combinational accept so outputs drop to 0 at once
        w_accept = (r_state == ST_IDLE) && i_rd_en && i_rst_n;
        w_oob    = (i_transfer_sz == SZ_ILL) || (w_end > {1'b0, i_packet_len}) ||
                   (w_end > MEM_BYTES);
        w_span   = ({1'b0, i_byte_addr[1:0]} + w_n) > 3'd4;
        w_rd_ok  = w_accept && !w_oob;
    end

    always_comb begin
        o_bram_rd_en = 1'b0;
        o_bram_addr  = '0;
        if (w_rd_ok) begin
            o_bram_rd_en = 1'b1;
            o_bram_addr  = PACKET_ADDR_WIDTH'(i_byte_addr[PACKET_BYTE_ADDR_WIDTH-1:2]);
        end else if (r_state == ST_RD1) begin
            o_bram_rd_en = 1'b1;
            o_bram_addr  = r_word + ONE_WORD;
        end
    end

    // The last word of a request is consumed straight off the BRAM bus in its arrival cycle
    assign w_window = r_span ? {r_w0, i_bram_rdata} : {i_bram_rdata, 32'h0000_0000};

    bpf_byte_extract u_extract (
        .i_window (w_window),
        .i_offset (r_off),
        .i_sz     (r_sz),
        .o_value  (w_value)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_word      <= '0;
            r_off       <= '0;
            r_sz        <= SZ_W;
            r_span      <= 1'b0;
            r_w0        <= '0;
            r_w0_pipe   <= '0;
            r_rd_data   <= '0;
            r_mem_ready <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            r_mem_ready  <= 1'b0;
            r_oob        <= 1'b0;
            // Tracks the first word of a span through the BRAM pipeline
            r_w0_pipe[0] <= w_rd_ok && w_span;
            for (int i = 1; i < int'(BRAM_LATENCY); i++) begin
                r_w0_pipe[i] <= r_w0_pipe[i-1];
            end
            if (r_w0_pipe[BRAM_LATENCY-1]) begin
                r_w0 <= i_bram_rdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_word <= PACKET_ADDR_WIDTH'(i_byte_addr[PACKET_BYTE_ADDR_WIDTH-1:2]);
                        r_off  <= i_byte_addr[1:0];
                        r_sz   <= i_transfer_sz;
                        r_span <= w_span;
                        r_cnt  <= LAT_M1;
                        if (w_oob) begin
                            r_state     <= ST_ERR;
                            r_mem_ready <= 1'b1;
                            r_oob       <= 1'b1;
                            r_rd_data   <= '0;
                        end else begin
                            r_state <= w_span ? ST_RD1 : ST_WAIT;
                        end
                    end
                end
                ST_RD1: begin
                    r_state <= ST_WAIT;
                    r_cnt   <= LAT_M1;
                end
                ST_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state     <= ST_DONE;
                        r_mem_ready <= 1'b1;
                        r_rd_data   <= w_value;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_DONE, ST_ERR: r_state <= ST_IDLE;
                default:         r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rd_data   = r_rd_data;
    assign o_mem_ready = r_mem_ready;
    assign o_oob       = r_oob;

endmodule

// File: tb/tb_bpf_pkt_rd_port.sv
// Bench for bpf_pkt_rd_port: latency-1 and latency-2 instances side by side against a byte-level model.
module tb_bpf_pkt_rd_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en1, rd_en2;
    logic [11:0] byte_addr;
    logic [1:0]  transfer_sz;
    logic [31:0] packet_len;

    logic [31:0] rd1, rd2;
    logic        rdy1, rdy2, oob1, oob2, bre1, bre2;
    logic [9:0]  ba1, ba2;
    logic [31:0] brd1, brd2;

    logic [31:0] mem [1024];
    logic        p2_v;
    logic [31:0] p2_d;

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;
    int rdc1 = 0, rdc2 = 0, rdyc1 = 0, rdyc2 = 0;
    logic [9:0] rq1 [$];
    logic [9:0] rq2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bpf_pkt_rd_port #(.PACKET_BYTE_ADDR_WIDTH(12), .BRAM_LATENCY(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en1), .i_byte_addr(byte_addr),
        .i_transfer_sz(transfer_sz), .i_packet_len(packet_len), .o_rd_data(rd1),
        .o_mem_ready(rdy1), .o_oob(oob1), .o_bram_rd_en(bre1), .o_bram_addr(ba1),
        .i_bram_rdata(brd1)
    );

    bpf_pkt_rd_port #(.PACKET_BYTE_ADDR_WIDTH(12), .BRAM_LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en2), .i_byte_addr(byte_addr),
        .i_transfer_sz(transfer_sz), .i_packet_len(packet_len), .o_rd_data(rd2),
        .o_mem_ready(rdy2), .o_oob(oob2), .o_bram_rd_en(bre2), .o_bram_addr(ba2),
        .i_bram_rdata(brd2)
    );

    // BRAM models; the bus carries junk whenever no read is returning
    always @(posedge clk) begin
        if (bre1) brd1 <= mem[ba1];
        else      brd1 <= $urandom;
    end
    always @(posedge clk) begin
        p2_v <= bre2;
        p2_d <= mem[ba2];
        brd2 <= p2_v ? p2_d : $urandom;
    end

    always @(negedge clk) begin
        if (bre1) begin rdc1 <= rdc1 + 1; rq1.push_back(ba1); end
        if (bre2) begin rdc2 <= rdc2 + 1; rq2.push_back(ba2); end
        if (rdy1) rdyc1 <= rdyc1 + 1;
        if (rdy2) rdyc2 <= rdyc2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input int a, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            int b;
            logic [31:0] w;
            b = a + i;
            w = mem[b / 4];
            v = (v << 8) | ((w >> (8 * (3 - (b % 4)))) & 32'hFF);
        end
        return v;
    endfunction

    task automatic do_req(input logic [1:0] sz, input logic [11:0] addr, input logic [31:0] len,
                          input bit chg_len);
        int n, lat1, lat2, t0, b1, b2, y1, y2, nrd;
        bit e_oob, span, done1, done2;
        logic [32:0] endb;
        logic [31:0] e_val, d1, d2;
        logic o1, o2;

        n     = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        endb  = 33'(addr) + 33'(n);
        e_oob = (sz == 2'b11) || (endb > {1'b0, len}) || (endb > 33'd4096);
        span  = (int'(addr) % 4) + n > 4;
        nrd   = e_oob ? 0 : (span ? 2 : 1);
        e_val = e_oob ? 32'h0 : ref_load(int'(addr), n);

        @(posedge clk); #1;
        t0 = cyc; b1 = rdc1; b2 = rdc2; y1 = rdyc1; y2 = rdyc2;
        done1 = 0; done2 = 0; lat1 = 0; lat2 = 0; d1 = 0; d2 = 0; o1 = 0; o2 = 0;
        transfer_sz = sz; byte_addr = addr; packet_len = len;
        rd_en1 = 1'b1; rd_en2 = 1'b1;
        for (int k = 0; k < 20 && !(done1 && done2); k++) begin
            @(negedge clk);
            if (chg_len && k == 1) packet_len = $urandom;
            if (!done1 && rdy1) begin
                done1 = 1; lat1 = cyc - t0; d1 = rd1; o1 = oob1; rd_en1 = 1'b0;
            end
            if (!done2 && rdy2) begin
                done2 = 1; lat2 = cyc - t0; d2 = rd2; o2 = oob2; rd_en2 = 1'b0;
            end
        end
        rd_en1 = 1'b0; rd_en2 = 1'b0;
        check("l1_done", 32'(done1), 32'd1);
        check("l2_done", 32'(done2), 32'd1);
        repeat (3) @(negedge clk);

        check("l1_rd_data", d1, e_val);
        check("l2_rd_data", d2, e_val);
        check("l1_oob", 32'(o1), 32'(e_oob));
        check("l2_oob", 32'(o2), 32'(e_oob));
        check("l1_latency", 32'(lat1), e_oob ? 32'd1 : 32'(nrd + 1));
        check("l2_latency", 32'(lat2), e_oob ? 32'd1 : 32'(nrd + 2));
        check("l1_nreads", 32'(rdc1 - b1), 32'(nrd));
        check("l2_nreads", 32'(rdc2 - b2), 32'(nrd));
        check("l1_nstrobes", 32'(rdyc1 - y1), 32'd1);
        check("l2_nstrobes", 32'(rdyc2 - y2), 32'd1);
        for (int k = 0; k < nrd; k++) begin
            if (b1 + k < rq1.size()) check("l1_raddr", 32'(rq1[b1 + k]), 32'(addr / 4 + k));
            else check("l1_raddr_missing", 32'd0, 32'd1);
            if (b2 + k < rq2.size()) check("l2_raddr", 32'(rq2[b2 + k]), 32'(addr / 4 + k));
            else check("l2_raddr_missing", 32'd0, 32'd1);
        end
    endtask

    initial begin
        int y1, y2;
        logic [1:0]  sz;
        logic [11:0] a;
        logic [31:0] len;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        rst_n = 1'b0; rd_en1 = 1'b1; rd_en2 = 1'b1;
        byte_addr = 12'd0; transfer_sz = 2'b00; packet_len = 32'd8;
        repeat (2) @(negedge clk);
        check("rst_rd_data", rd1 | rd2, 32'h0);
        check("rst_ready", 32'({rdy1, rdy2, oob1, oob2}), 32'h0);
        check("rst_bram", 32'({bre1, bre2}) | 32'(ba1) | 32'(ba2), 32'h0);
        rd_en1 = 1'b0; rd_en2 = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_req(2'b00, 12'd0, 32'd8, 0);
        do_req(2'b10, 12'd5, 32'd8, 0);
        do_req(2'b01, 12'd2, 32'd8, 0);
        do_req(2'b01, 12'd3, 32'd8, 1);
        do_req(2'b00, 12'd1, 32'd8, 0);
        do_req(2'b00, 12'd6, 32'd8, 0);
        do_req(2'b10, 12'd8, 32'd8, 0);
        do_req(2'b11, 12'd0, 32'd8, 0);
        do_req(2'b10, 12'd7, 32'd8, 1);

        // Reset landing in cycle 1 of a span read
        @(posedge clk); #1;
        y1 = rdyc1; y2 = rdyc2;
        transfer_sz = 2'b00; byte_addr = 12'd1; packet_len = 32'd8;
        rd_en1 = 1'b1; rd_en2 = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outs1", rd1 | 32'(ba1) | 32'({rdy1, oob1, bre1}), 32'h0);
        check("midrst_outs2", rd2 | 32'(ba2) | 32'({rdy2, oob2, bre2}), 32'h0);
        rd_en1 = 1'b0; rd_en2 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_strobe", 32'(rdyc1 - y1) + 32'(rdyc2 - y2), 32'h0);
        do_req(2'b00, 12'd4, 32'd8, 0);

        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) a = 12'($urandom_range(4088, 4095));
            else a = 12'($urandom_range(0, 4095));
            case ($urandom_range(0, 3))
                0:       len = 32'hFFFF_FFFF;
                1:       len = 32'($urandom_range(0, 4200));
                default: len = 32'(a) + 32'($urandom_range(0, 5));
            endcase
            do_req(sz, a, len, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
